lif_neuron: RTL and testbench

Registered leaky integrate-and-fire neuron stage. It sits directly downstream of the combinational two-input synaptic summing stage and consumes that stage's 8-bit drive word. It integrates the drive into a membrane potential with leak, emits a one-cycle spike when the potential reaches threshold, then enforces a refractory period. Optionally, it adapts its threshold from reward/punish feedback.

---
 rtl/snn_pkg.sv | 16 +
 rtl/lif_neuron_if.sv | 14 +
 rtl/lif_threshold_adapt.sv | 49 ++++
 rtl/lif_neuron.sv | 104 ++++++++++
 tb/tb_lif_neuron.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN widths, threshold bounds and neuron state encoding
package snn_pkg;

  // Common drive/membrane width so the summing stage and the neuron agree
  localparam int SNN_WIDTH = 8;

  localparam logic [SNN_WIDTH-1:0] SNN_THRESH_INIT = 8'h20;
  localparam logic [SNN_WIDTH-1:0] SNN_THRESH_MIN  = 8'h08;
  localparam logic [SNN_WIDTH-1:0] SNN_THRESH_MAX  = 8'hF0;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

endpackage

// File: rtl/lif_neuron_if.sv
// rtl/lif_neuron_if.sv - synaptic drive bus from the summing stage into the neuron
interface lif_neuron_if
  import snn_pkg::*;
#(
  parameter int WIDTH = SNN_WIDTH
);

  logic [WIDTH-1:0] drive_in;
  logic             drive_valid;

  modport master (output drive_in, output drive_valid);
  modport slave  (input  drive_in, input  drive_valid);

endinterface

// File: rtl/lif_threshold_adapt.sv
// rtl/lif_threshold_adapt.sv - eligibility flag and saturating reward/punish threshold update
module lif_threshold_adapt
  import snn_pkg::*;
#(
  parameter int               WIDTH       = SNN_WIDTH,
  parameter logic [WIDTH-1:0] THRESH_INIT = SNN_THRESH_INIT,
  parameter int               THRESH_STEP = 4,
  parameter logic [WIDTH-1:0] THRESH_MIN  = SNN_THRESH_MIN,
  parameter logic [WIDTH-1:0] THRESH_MAX  = SNN_THRESH_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             fire,
  input  logic             reward,
  input  logic             punish,
  output logic [WIDTH-1:0] threshold
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(THRESH_STEP);

  logic eligible;

  // Adapt only when the neuron has spiked since the last adaptation;
  // a spike in the adapting cycle re-arms eligibility.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold <= THRESH_INIT;
      eligible  <= 1'b0;
    end else if (ena) begin
      if (eligible && reward && !punish) begin
        if ({1'b0, threshold} < ({1'b0, THRESH_MIN} + STEP_X))
          threshold <= THRESH_MIN;
        else
          threshold <= threshold - STEP_X[WIDTH-1:0];
        eligible <= fire;
      end else if (eligible && punish && !reward) begin
        if (({1'b0, threshold} + STEP_X) > {1'b0, THRESH_MAX})
          threshold <= THRESH_MAX;
        else
          threshold <= threshold + STEP_X[WIDTH-1:0];
        eligible <= fire;
      end else if (fire) begin
        eligible <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron; LIF_REWARD_EN enables threshold adaptation
module lif_neuron
  import snn_pkg::*;
#(
  parameter int               WIDTH         = SNN_WIDTH,
  parameter logic [WIDTH-1:0] THRESH_INIT   = SNN_THRESH_INIT,
  parameter int               LEAK_SHIFT    = 3,
  parameter int               REFRAC_CYCLES = 4,
  parameter int               THRESH_STEP   = 4,
  parameter logic [WIDTH-1:0] THRESH_MIN    = SNN_THRESH_MIN,
  parameter logic [WIDTH-1:0] THRESH_MAX    = SNN_THRESH_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  lif_neuron_if.slave      drv,
  input  logic             reward,
  input  logic             punish,
  output logic             spike,
  output logic [WIDTH-1:0] membrane,
  output logic [WIDTH-1:0] threshold,
  output logic             refractory,
  output logic [7:0]       spike_count
);

  lif_state_e       state;
  logic [3:0]       refr_cnt;
  logic [WIDTH-1:0] v_shr;
  logic [WIDTH-1:0] leak;
  logic [WIDTH-1:0] drive_term;
  logic [WIDTH:0]   sum;
  logic             fire;

  // Leak, drive accumulation and threshold compare for the integrating state
  always_comb begin
    v_shr = membrane >> LEAK_SHIFT;
    leak  = '0;
    if (membrane != '0)
      leak = (v_shr == '0) ? WIDTH'(1) : v_shr;
    drive_term = drv.drive_valid ? drv.drive_in : '0;
    sum  = {1'b0, membrane} - {1'b0, leak} + {1'b0, drive_term};
    fire = ena && (state == INTEGRATE) && (sum >= {1'b0, threshold});
  end

  // Integrate/refractory state machine with registered spike and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INTEGRATE;
      membrane    <= '0;
      refr_cnt    <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else if (!ena) begin
      spike <= 1'b0;
    end else begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            membrane    <= '0;
            spike       <= 1'b1;
            spike_count <= spike_count + 8'd1;
            refr_cnt    <= 4'(REFRAC_CYCLES);
            state       <= REFRACTORY;
          end else begin
            membrane <= sum[WIDTH-1:0];
            spike    <= 1'b0;
          end
        end
        REFRACTORY: begin
          membrane <= '0;
          spike    <= 1'b0;
          refr_cnt <= refr_cnt - 4'd1;
          if (refr_cnt == 4'd1)
            state <= INTEGRATE;
        end
      endcase
    end
  end

  assign refractory = (state == REFRACTORY);

`ifdef LIF_REWARD_EN
  lif_threshold_adapt #(
    .WIDTH       (WIDTH),
    .THRESH_INIT (THRESH_INIT),
    .THRESH_STEP (THRESH_STEP),
    .THRESH_MIN  (THRESH_MIN),
    .THRESH_MAX  (THRESH_MAX)
  ) u_adapt (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .fire      (fire),
    .reward    (reward),
    .punish    (punish),
    .threshold (threshold)
  );
`else
  logic _unused;
  assign threshold = THRESH_INIT;
  assign _unused   = &{1'b0, reward, punish, THRESH_MIN, THRESH_MAX, 32'(THRESH_STEP)};
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - randomized self-checking bench for lif_neuron against a behavioural model
module tb_lif_neuron;
  import snn_pkg::*;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       ena    = 1'b0;
  logic       reward = 1'b0;
  logic       punish = 1'b0;
  logic       spike;
  logic       refractory;
  logic [7:0] membrane;
  logic [7:0] threshold;
  logic [7:0] spike_count;
  logic [25:0] obs;

  lif_neuron_if bus ();

  lif_neuron dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .drv         (bus),
    .reward      (reward),
    .punish      (punish),
    .spike       (spike),
    .membrane    (membrane),
    .threshold   (threshold),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  assign obs = {spike, membrane, threshold, refractory, spike_count};

  int errors = 0;
  int checks = 0;

  localparam logic [25:0] RESET_OBS = {1'b0, 8'h00, 8'h20, 1'b0, 8'h00};

  // Behavioural model: membrane value, threshold, remaining refractory cycles, spike total
  int m_v, m_thr, m_refr, m_cnt;
  bit m_spike, m_elig;

  task automatic model_reset();
    m_v = 0; m_thr = 32; m_refr = 0; m_cnt = 0; m_spike = 0; m_elig = 0;
  endtask

  task automatic model_step(bit e, bit val, int d, bit rw, bit pn);
    int  lk, s;
    bit  fired;
    if (!e) begin
      m_spike = 0;
      return;
    end
    fired = 0;
    if (m_refr > 0) begin
      m_refr = m_refr - 1;
      m_v = 0;
    end else begin
      lk = (m_v == 0) ? 0 : ((m_v / 8 == 0) ? 1 : m_v / 8);
      s = m_v - lk + (val ? d : 0);
      if (s >= m_thr) begin
        fired = 1; m_v = 0; m_cnt = (m_cnt + 1) % 256; m_refr = 4;
      end else begin
        m_v = s;
      end
    end
    m_spike = fired;
`ifdef LIF_REWARD_EN
    if (m_elig && rw && !pn) begin
      m_thr = (m_thr - 4 < 8) ? 8 : m_thr - 4;
      m_elig = fired;
    end else if (m_elig && pn && !rw) begin
      m_thr = (m_thr + 4 > 240) ? 240 : m_thr + 4;
      m_elig = fired;
    end else if (fired) begin
      m_elig = 1;
    end
`else
    if (rw && pn) m_elig = 0;
`endif
  endtask

  function automatic logic [25:0] expv();
    return {m_spike, 8'(m_v), 8'(m_thr), (m_refr > 0), 8'(m_cnt)};
  endfunction

  task automatic tick(bit e, bit val, logic [7:0] d, bit rw = 0, bit pn = 0);
    ena = e; bus.drive_valid = val; bus.drive_in = d; reward = rw; punish = pn;
    @(posedge clk);
    model_step(e, val, int'(d), rw, pn);
    #1;
  endtask

  task automatic do_reset();
    ena = 0; bus.drive_valid = 0; bus.drive_in = '0; reward = 0; punish = 0;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.drive_valid = 0; bus.drive_in = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_OBS) begin
      errors++; $display("FAIL reset_initial obs=%h exp=%h", obs, RESET_OBS);
    end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1, 1, 8'h30);
    tick(1, 0, 8'h00);
    checks++;
    if (refractory !== 1'b1) begin
      errors++; $display("FAIL reset_pre_refr refractory=%b exp=1", refractory);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== RESET_OBS) begin
      errors++; $display("FAIL reset_mid_refr obs=%h exp=%h", obs, RESET_OBS);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single_spike();
    int refr_hi, spk_hi;
    do_reset();
    tick(1, 1, 8'h30);
    checks++;
    if ({spike, membrane, refractory, spike_count} !== {1'b1, 8'h00, 1'b1, 8'h01}) begin
      errors++; $display("FAIL single_fire spike=%b mem=%h refr=%b cnt=%h exp 1 00 1 01",
                         spike, membrane, refractory, spike_count);
    end
    refr_hi = 1; spk_hi = 1;
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 8'h00);
      refr_hi += refractory;
      spk_hi  += spike;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL single_seq i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    checks++;
    if (refr_hi != 4 || spk_hi != 1) begin
      errors++; $display("FAIL single_widths refr_cycles=%0d exp=4 spike_cycles=%0d exp=1", refr_hi, spk_hi);
    end
  endtask

  task automatic test_leak_decay();
    logic [7:0] first [4];
    first[0] = 8'h10; first[1] = 8'h0E; first[2] = 8'h0D; first[3] = 8'h0C;
    do_reset();
    tick(1, 1, 8'h10);
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        checks++;
        if (membrane !== first[i]) begin
          errors++; $display("FAIL leak_seq i=%0d mem=%h exp=%h", i, membrane, first[i]);
        end
      end
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL leak_model i=%0d obs=%h exp=%h", i, obs, expv());
      end
      tick(1, 0, 8'h00);
    end
    checks++;
    if (membrane !== 8'h00) begin
      errors++; $display("FAIL leak_floor mem=%h exp=00", membrane);
    end
  endtask

  task automatic test_refractory_drop();
    do_reset();
    tick(1, 1, 8'h30);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 8'hFF);
      checks++;
      if (spike !== 1'b0 || membrane !== 8'h00 || obs !== expv()) begin
        errors++; $display("FAIL refr_drop i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    tick(1, 1, 8'hFF);
    checks++;
    if (spike !== 1'b1 || spike_count !== 8'h02) begin
      errors++; $display("FAIL refr_refire spike=%b cnt=%h exp 1 02", spike, spike_count);
    end
  endtask

  task automatic test_ena_freeze();
    do_reset();
    tick(1, 1, 8'h30);
    tick(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 8'hFF);
      checks++;
      if (refractory !== 1'b1 || spike !== 1'b0 || obs !== expv()) begin
        errors++; $display("FAIL ena_frozen i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    tick(1, 0, 8'h00);
    tick(1, 0, 8'h00);
    checks++;
    if (refractory !== 1'b1) begin
      errors++; $display("FAIL ena_still_refr refractory=%b exp=1", refractory);
    end
    tick(1, 0, 8'h00);
    checks++;
    if (refractory !== 1'b0 || obs !== expv()) begin
      errors++; $display("FAIL ena_refr_end obs=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      tick(1, 1, 8'hFF);
      if (n == 255 || n == 256) begin
        checks++;
        if (spike_count !== 8'(n)) begin
          errors++; $display("FAIL wrap_count n=%0d cnt=%h exp=%h", n, spike_count, 8'(n));
        end
      end
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL wrap_model n=%0d obs=%h exp=%h", n, obs, expv());
      end
      for (int k = 0; k < 4; k++) tick(1, 0, 8'h00);
    end
  endtask

  task automatic test_random();
    bit         e, val;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e   = ($urandom_range(0, 9) != 0);
      val = $urandom_range(0, 1);
      d   = 8'($urandom_range(0, 8'h28));
      tick(e, val, d);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
  endtask

`ifdef LIF_REWARD_EN
  task automatic test_reward();
    do_reset();
    tick(1, 1, 8'h30);
    tick(1, 0, 8'h00, 1, 0);
    checks++;
    if (threshold !== 8'h1C) begin
      errors++; $display("FAIL reward_step thr=%h exp=1C", threshold);
    end
    tick(1, 0, 8'h00, 0, 1);
    checks++;
    if (threshold !== 8'h1C || obs !== expv()) begin
      errors++; $display("FAIL punish_inelig thr=%h exp=1C", threshold);
    end
    do_reset();
    for (int n = 0; n < 7; n++) begin
      tick(1, 1, 8'hFF);
      tick(1, 0, 8'h00, 1, 0);
      for (int k = 0; k < 4; k++) tick(1, 0, 8'h00);
    end
    checks++;
    if (threshold !== 8'h08 || obs !== expv()) begin
      errors++; $display("FAIL reward_sat thr=%h exp=08", threshold);
    end
  endtask
`endif

  initial begin
    bus.drive_valid = 1'b0;
    bus.drive_in    = '0;
    model_reset();
    test_reset();
    test_single_spike();
    test_leak_decay();
    test_refractory_drop();
    test_ena_freeze();
    test_count_wrap();
    test_random();
`ifdef LIF_REWARD_EN
    test_reward();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
